pc_flow_control: RTL and testbench

- Producer and consumer side of the next-PC select path in the 8-bit single-cycle processor.
- Holds the program counter and computes PC+4 and the branch/jump target.
- Decides the flow select from the control unit's JUMP/BEQ/BNE and the ALU ZERO flag, then registers the chosen next PC.
- Honours the memory BUSYWAIT stall and counts retired instructions.

---
 rtl/pc_flow_pkg.sv | 24 ++
 rtl/pc_flow_if.sv | 46 ++++
 rtl/pc_next_mux.sv | 18 +
 rtl/pc_flow_control.sv | 97 +++++++++
 tb/tb_pc_flow_control.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/pc_flow_pkg.sv
// pc_flow_pkg
// Shared definitions for the next-PC select path of the 8-bit single-cycle
// processor: the commit state machine encoding, the sequential PC increment,
// the default reset PC and the branch/jump decision helper.
package pc_flow_pkg;

  // 2'd3 is not a legal state; the top level steers it back to STATE_RUN.
  typedef enum logic [1:0] {
    STATE_HOLD  = 2'd0,
    STATE_RUN   = 2'd1,
    STATE_STALL = 2'd2
  } state_t;

  localparam int          PC_INC           = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // JUMP dominates; with BEQ and BNE both set one of them always holds,
  // so the branch is taken regardless of ZERO.
  function automatic logic flowSelect(input logic jump, input logic beq,
                                      input logic bne, input logic zero);
    return jump | (beq & zero) | (bne & ~zero);
  endfunction

endpackage

// File: rtl/pc_flow_if.sv
// pc_flow_if
// Bundles the control-unit/memory inputs and the PC-path outputs of
// pc_flow_control.
//   master : drives JUMP, BEQ, BNE, ZERO, OFFSET, BUSYWAIT; observes the rest
//   slave  : the PC path itself (pc_flow_control)
// Signals:
//   JUMP/BEQ/BNE  control-unit flow requests for the current instruction
//   ZERO          ALU zero flag
//   OFFSET        signed branch/jump offset in instruction words
//   BUSYWAIT      instruction/data memory stall
//   PC            current program counter
//   PC_PLUS4      sequential next PC
//   TARGET        branch/jump target
//   FLOW_SEL      1 = TARGET selected, 0 = PC_PLUS4 selected
//   STALLED       high while the commit FSM is stalled
//   RETIRED       count of committed PC advances
interface pc_flow_if #(
  parameter int PC_W  = 32,
  parameter int OFF_W = 8,
  parameter int CNT_W = 16
);

  logic             JUMP;
  logic             BEQ;
  logic             BNE;
  logic             ZERO;
  logic [OFF_W-1:0] OFFSET;
  logic             BUSYWAIT;
  logic [PC_W-1:0]  PC;
  logic [PC_W-1:0]  PC_PLUS4;
  logic [PC_W-1:0]  TARGET;
  logic             FLOW_SEL;
  logic             STALLED;
  logic [CNT_W-1:0] RETIRED;

  modport master (
    output JUMP, BEQ, BNE, ZERO, OFFSET, BUSYWAIT,
    input  PC, PC_PLUS4, TARGET, FLOW_SEL, STALLED, RETIRED
  );

  modport slave (
    input  JUMP, BEQ, BNE, ZERO, OFFSET, BUSYWAIT,
    output PC, PC_PLUS4, TARGET, FLOW_SEL, STALLED, RETIRED
  );

endinterface

// File: rtl/pc_next_mux.sv
// pc_next_mux
// 2:1 next-PC selector.
//   i_sel  : 0 = sequential PC (i_seq), 1 = branch/jump target (i_tgt)
//   i_seq  : PC + 4
//   i_tgt  : branch/jump target
//   o_next : selected next PC
module pc_next_mux #(
  parameter int W = 32
) (
  input  logic         i_sel,
  input  logic [W-1:0] i_seq,
  input  logic [W-1:0] i_tgt,
  output logic [W-1:0] o_next
);

  assign o_next = i_sel ? i_tgt : i_seq;

endmodule

// File: rtl/pc_flow_control.sv
// pc_flow_control
// Program counter and next-PC select path of the 8-bit single-cycle
// processor. Computes PC+4 and the branch/jump target, decides the flow
// select, and commits the chosen next PC unless memory is stalling. Counts
// the instructions whose PC advance committed.
// Ports:
//   CLK    : clock, all state changes on the rising edge
//   RESET  : asynchronous active-low reset
//   bus    : pc_flow_if slave modport (controls in, PC path outputs out)
module pc_flow_control
  import pc_flow_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              OFF_W    = 8,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT),
  parameter int              CNT_W    = 16
) (
  input  logic    CLK,
  input  logic    RESET,
  pc_flow_if.slave bus
);

  state_t           r_state;
  logic [PC_W-1:0]  r_pc;
  logic [CNT_W-1:0] r_retired;
  logic             r_stalled;

  logic [PC_W-1:0]  w_pcPlus4;
  logic [PC_W-1:0]  w_offExt;
  logic [PC_W-1:0]  w_target;
  logic             w_flowSel;
  logic [PC_W-1:0]  w_nextPc;

  // Offset counts instruction words, so it is sign-extended and scaled by 4.
  // Sums wrap silently in both directions.
  assign w_pcPlus4 = r_pc + PC_W'(PC_INC);
  assign w_offExt  = {{(PC_W-OFF_W-2){bus.OFFSET[OFF_W-1]}}, bus.OFFSET, 2'b00};
  assign w_target  = w_pcPlus4 + w_offExt;
  assign w_flowSel = flowSelect(bus.JUMP, bus.BEQ, bus.BNE, bus.ZERO);

  pc_next_mux #(
    .W (PC_W)
  ) u_nextMux (
    .i_sel  (w_flowSel),
    .i_seq  (w_pcPlus4),
    .i_tgt  (w_target),
    .o_next (w_nextPc)
  );

  // HOLD gives the first fetch one edge to settle. A stall exit commits on
  // the very edge BUSYWAIT drops, using the inputs present at that edge,
  // so there is no bubble after a stall.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state   <= STATE_HOLD;
      r_pc      <= RESET_PC;
      r_retired <= '0;
      r_stalled <= 1'b0;
    end else begin
      case (r_state)
        STATE_HOLD: begin
          r_state   <= STATE_RUN;
          r_stalled <= 1'b0;
        end
        STATE_RUN: begin
          if (bus.BUSYWAIT) begin
            r_state   <= STATE_STALL;
            r_stalled <= 1'b1;
          end else begin
            r_pc      <= w_nextPc;
            r_retired <= r_retired + CNT_W'(1);
          end
        end
        STATE_STALL: begin
          if (!bus.BUSYWAIT) begin
            r_pc      <= w_nextPc;
            r_retired <= r_retired + CNT_W'(1);
            r_state   <= STATE_RUN;
            r_stalled <= 1'b0;
          end
        end
        default: begin
          r_state   <= STATE_RUN;
          r_stalled <= 1'b0;
        end
      endcase
    end
  end

  assign bus.PC       = r_pc;
  assign bus.PC_PLUS4 = w_pcPlus4;
  assign bus.TARGET   = w_target;
  assign bus.FLOW_SEL = w_flowSel;
  assign bus.STALLED  = r_stalled;
  assign bus.RETIRED  = r_retired;

endmodule

// File: tb/tb_pc_flow_control.sv
// tb_pc_flow_control
// Directed, table-driven bench for pc_flow_control: reset state, sequential
// run, forward/backward branches, BNE/JUMP priority, stall hold and release,
// PC wrap-around, target wrap-around, async reset mid-stall and retired
// counter wrap.
module tb_pc_flow_control;

  logic CLK;
  logic RESET;

  int checks;
  int errors;

  pc_flow_if #(.PC_W(32), .OFF_W(8), .CNT_W(16)) bus ();

  pc_flow_control #(
    .PC_W     (32),
    .OFF_W    (8),
    .RESET_PC (32'h0000_0000),
    .CNT_W    (16)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        jump;
    logic        beq;
    logic        bne;
    logic        zero;
    logic        busy;
    logic [7:0]  off;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        flow;
    logic [31:0] nextPc;
    logic [15:0] ret;
    logic        stl;
  } vec_t;

  vec_t vecs [19];

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic jump, input logic beq,
                               input logic bne, input logic zero,
                               input logic busy, input logic [7:0] off);
    bus.JUMP     = jump;
    bus.BEQ      = beq;
    bus.BNE      = bne;
    bus.ZERO     = zero;
    bus.BUSYWAIT = busy;
    bus.OFFSET   = off;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    //            j  beq bne z  busy off    pc            target        flow next          ret    stl
    vecs[0]  = '{0, 0, 0, 0, 0, 8'h00, 32'h0000_0000, 32'h0000_0004, 0, 32'h0000_0004, 16'd1,  0};
    vecs[1]  = '{0, 0, 0, 0, 0, 8'h00, 32'h0000_0004, 32'h0000_0008, 0, 32'h0000_0008, 16'd2,  0};
    vecs[2]  = '{0, 0, 0, 0, 0, 8'h00, 32'h0000_0008, 32'h0000_000C, 0, 32'h0000_000C, 16'd3,  0};
    vecs[3]  = '{0, 0, 0, 0, 0, 8'h00, 32'h0000_000C, 32'h0000_0010, 0, 32'h0000_0010, 16'd4,  0};
    vecs[4]  = '{0, 1, 0, 1, 0, 8'h02, 32'h0000_0010, 32'h0000_001C, 1, 32'h0000_001C, 16'd5,  0};
    vecs[5]  = '{0, 1, 0, 1, 0, 8'hFE, 32'h0000_001C, 32'h0000_0018, 1, 32'h0000_0018, 16'd6,  0};
    vecs[6]  = '{0, 1, 0, 0, 0, 8'h02, 32'h0000_0018, 32'h0000_0024, 0, 32'h0000_001C, 16'd7,  0};
    vecs[7]  = '{0, 0, 0, 0, 0, 8'h00, 32'h0000_001C, 32'h0000_0020, 0, 32'h0000_0020, 16'd8,  0};
    vecs[8]  = '{0, 0, 1, 0, 0, 8'h01, 32'h0000_0020, 32'h0000_0028, 1, 32'h0000_0028, 16'd9,  0};
    vecs[9]  = '{1, 0, 1, 1, 0, 8'h00, 32'h0000_0028, 32'h0000_002C, 1, 32'h0000_002C, 16'd10, 0};
    vecs[10] = '{0, 1, 1, 0, 0, 8'h03, 32'h0000_002C, 32'h0000_003C, 1, 32'h0000_003C, 16'd11, 0};
    vecs[11] = '{0, 0, 0, 0, 0, 8'h00, 32'h0000_003C, 32'h0000_0040, 0, 32'h0000_0040, 16'd12, 0};
    vecs[12] = '{1, 0, 0, 0, 1, 8'h04, 32'h0000_0040, 32'h0000_0054, 1, 32'h0000_0040, 16'd12, 1};
    vecs[13] = '{1, 0, 0, 0, 1, 8'h7F, 32'h0000_0040, 32'h0000_0240, 1, 32'h0000_0040, 16'd12, 1};
    vecs[14] = '{1, 0, 0, 0, 1, 8'h04, 32'h0000_0040, 32'h0000_0054, 1, 32'h0000_0040, 16'd12, 1};
    vecs[15] = '{1, 0, 0, 0, 0, 8'h04, 32'h0000_0040, 32'h0000_0054, 1, 32'h0000_0054, 16'd13, 0};
    vecs[16] = '{1, 0, 0, 0, 0, 8'hE9, 32'h0000_0054, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 16'd14, 0};
    vecs[17] = '{0, 0, 0, 0, 0, 8'h00, 32'hFFFF_FFFC, 32'h0000_0000, 0, 32'h0000_0000, 16'd15, 0};
    vecs[18] = '{0, 0, 0, 0, 0, 8'h80, 32'h0000_0000, 32'hFFFF_FE04, 0, 32'h0000_0004, 16'd16, 0};

    // Reset state, checked while reset is still held.
    RESET = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 8'h00);
    #1;
    checkOutput("reset_pc",      bus.PC,               32'h0);
    checkOutput("reset_retired", 32'(bus.RETIRED),     32'h0);
    checkOutput("reset_stalled", 32'(bus.STALLED),     32'h0);

    // HOLD edge after release: PC and RETIRED must not move.
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    checkOutput("hold_pc",      bus.PC,           32'h0);
    checkOutput("hold_retired", 32'(bus.RETIRED), 32'h0);

    for (int i = 0; i < 19; i++) begin
      @(negedge CLK);
      applyStimulus(vecs[i].jump, vecs[i].beq, vecs[i].bne, vecs[i].zero,
                    vecs[i].busy, vecs[i].off);
      #1;
      checkOutput($sformatf("v%0d_pc", i),      bus.PC,            vecs[i].pc);
      checkOutput($sformatf("v%0d_plus4", i),   bus.PC_PLUS4,      vecs[i].pc + 32'd4);
      checkOutput($sformatf("v%0d_target", i),  bus.TARGET,        vecs[i].tgt);
      checkOutput($sformatf("v%0d_flow", i),    32'(bus.FLOW_SEL), 32'(vecs[i].flow));
      @(posedge CLK);
      #1;
      checkOutput($sformatf("v%0d_next", i),    bus.PC,            vecs[i].nextPc);
      checkOutput($sformatf("v%0d_retired", i), 32'(bus.RETIRED),  32'(vecs[i].ret));
      checkOutput($sformatf("v%0d_stalled", i), 32'(bus.STALLED),  32'(vecs[i].stl));
    end

    // Async reset mid-stall: jump from 0x4 to 0x40, stall, then drop RESET
    // between edges and expect an immediate clear.
    @(negedge CLK);
    applyStimulus(1, 0, 0, 0, 0, 8'h0E);
    @(posedge CLK);
    #1;
    checkOutput("seq_jump40", bus.PC, 32'h0000_0040);
    @(negedge CLK);
    applyStimulus(0, 0, 0, 0, 1, 8'h00);
    @(posedge CLK);
    #1;
    checkOutput("seq_stall_in", 32'(bus.STALLED), 32'h1);
    @(negedge CLK);
    #2;
    RESET = 1'b0;
    #1;
    checkOutput("areset_pc",      bus.PC,           32'h0);
    checkOutput("areset_retired", 32'(bus.RETIRED), 32'h0);
    checkOutput("areset_stalled", 32'(bus.STALLED), 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 8'h00);
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    checkOutput("rehold_pc", bus.PC, 32'h0);

    // Retired counter wrap: 65535 commits reach 16'hFFFF, one more wraps.
    repeat (65535) @(posedge CLK);
    #1;
    checkOutput("ret_ffff",     32'(bus.RETIRED), 32'h0000_FFFF);
    checkOutput("ret_ffff_pc",  bus.PC,           32'h0003_FFFC);
    @(posedge CLK);
    #1;
    checkOutput("ret_wrap",     32'(bus.RETIRED), 32'h0);
    checkOutput("ret_wrap_pc",  bus.PC,           32'h0004_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
